cache_set_assoc: RTL

- Parametrised N-way set storage with per-way valid/dirty/tag/data.
- Provides zero-latency lookup and hit detection, byte-enabled write-hit, and LRU victim selection.
- A sequential miss engine streams a dirty victim out for writeback, then accepts line-fill beats.
- Sits under the L1 I/D cache controller, one instance per index row; replaces the single-way line store.

---
 rtl/cache_pkg.sv | 13 +
 rtl/cache_lru.sv | 30 +++
 rtl/cache_set_assoc.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM encoding and sizing helpers for the set-associative line store.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  localparam int DEFAULT_WAYS = 2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lru_age_w(input int ways);
    return (ways < 2) ? 1 : clog2(ways);
  endfunction
endpackage

// File: rtl/cache_lru.sv
// cache_lru: per-set LRU age counters (0 = most recent) and victim pick.
module cache_lru import cache_pkg::*; #(
  parameter int WAYS = DEFAULT_WAYS,
  parameter int AW = lru_age_w(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            touch,
  input  logic [AW-1:0]   touch_way,
  input  logic [WAYS-1:0] valid,
  output logic [AW-1:0]   victim
);
  logic [AW-1:0] age_q [WAYS];
  logic [AW-1:0] old_age;
  assign old_age = age_q[touch_way];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < WAYS; i++) age_q[i] <= AW'(i);
    else if (touch)
      for (int i = 0; i < WAYS; i++)
        age_q[i] <= (AW'(i) == touch_way) ? '0 : (age_q[i] < old_age) ? age_q[i] + AW'(1) : age_q[i];
  // an invalid way always beats the oldest one; lowest index wins among invalids
  always_comb begin
    victim = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (age_q[i] == AW'(WAYS - 1)) victim = AW'(i);
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid[i]) victim = AW'(i);
  end
endmodule

// File: rtl/cache_set_assoc.sv
// cache_set_assoc: N-way set with lookup, byte write-hit, LRU and writeback/refill engine.
// Optional critical-word-first refill when CACHE_WRAP_FILL_EN is defined.
module cache_set_assoc import cache_pkg::*; #(
  parameter int TAG_WIDTH    = 20,
  parameter int OFFSET_WIDTH = 4,
  parameter int WAYS         = DEFAULT_WAYS,
  parameter int DATA_WIDTH   = 32,
  parameter int AW           = lru_age_w(WAYS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TAG_WIDTH-1:0]    lookup_tag,
  input  logic [OFFSET_WIDTH-1:0] lookup_offset,
  input  logic                    access_en,
  input  logic                    write_en,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic                    hit,
  output logic [AW-1:0]           hit_way,
  output logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    fill_req,
  output logic                    busy,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [TAG_WIDTH-1:0]    wb_tag,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    wb_last,
  input  logic                    fill_valid,
  input  logic [DATA_WIDTH-1:0]   fill_data,
  output logic                    fill_done
`ifdef CACHE_WRAP_FILL_EN
  ,output logic                   fill_word_ready
`endif
);
  localparam int LINE = 2 ** OFFSET_WIDTH;
  state_t state_q, state_d;
  logic [WAYS-1:0] valid_q, dirty_q, hit_vec;
  logic [TAG_WIDTH-1:0] tag_q [WAYS];
  logic [DATA_WIDTH-1:0] data_q [WAYS][LINE];
  logic [AW-1:0] vic_q, victim, hw, touch_way;
  logic [TAG_WIDTH-1:0] vtag_q;
  logic [OFFSET_WIDTH-1:0] cnt_q, start_off, last_idx;
  logic wr_hit, wb_hs, fill_beat, at_last, install, touch, start_miss, victim_dirty;
  always_comb begin
    hw = '0;
    for (int i = 0; i < WAYS; i++) hit_vec[i] = valid_q[i] && tag_q[i] == lookup_tag;
    for (int i = WAYS - 1; i >= 0; i--)
      if (hit_vec[i]) hw = AW'(i);
  end
  assign busy         = state_q != IDLE;
  assign hit          = |hit_vec && !busy;
  assign hit_way      = hw;
  assign read_data    = hit ? data_q[hw][lookup_offset] : '0;
  assign wr_hit       = access_en && write_en && hit;
  assign wb_valid     = state_q == WB;
  assign at_last      = cnt_q == last_idx;
  assign wb_last      = wb_valid && at_last;
  assign wb_data      = data_q[vic_q][cnt_q];
  assign wb_tag       = tag_q[vic_q];
  assign wb_hs        = wb_valid && wb_ready;
  assign fill_beat    = state_q == FILL && fill_valid;
  assign install      = fill_beat && at_last;
  assign touch        = install || (access_en && hit);
  assign touch_way    = install ? vic_q : hw;
  assign start_miss   = state_q == IDLE && fill_req;
  assign victim_dirty = valid_q[victim] && dirty_q[victim];
  cache_lru #(.WAYS(WAYS), .AW(AW)) u_lru (
    .clk(clk), .rst(rst), .touch(touch), .touch_way(touch_way), .valid(valid_q), .victim(victim)
  );
`ifdef CACHE_WRAP_FILL_EN
  logic [OFFSET_WIDTH-1:0] start_q;
  assign start_off = lookup_offset;
  assign last_idx  = start_q - OFFSET_WIDTH'(1);
  // the first refill beat always carries the requested word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      start_q <= '0;
      fill_word_ready <= 1'b0;
    end else begin
      fill_word_ready <= fill_beat && cnt_q == start_q;
      if (start_miss) start_q <= lookup_offset;
    end
`else
  assign start_off = '0;
  assign last_idx  = '1;
`endif
  always_comb begin
    state_d = state_q;
    if (start_miss) state_d = victim_dirty ? WB : FILL;
    else if (wb_hs && at_last) state_d = FILL;
    else if (install) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // valid drops on FILL entry so a partially refilled line can never hit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      cnt_q <= '0;
      vic_q <= '0;
      vtag_q <= '0;
      fill_done <= 1'b0;
      for (int i = 0; i < WAYS; i++) tag_q[i] <= '0;
    end else begin
      fill_done <= install;
      if (start_miss) begin
        vic_q <= victim;
        vtag_q <= lookup_tag;
        cnt_q <= start_off;
        if (!victim_dirty) valid_q[victim] <= 1'b0;
      end
      if (wb_hs || fill_beat) cnt_q <= cnt_q + OFFSET_WIDTH'(1);
      if (wb_hs && at_last) begin
        valid_q[vic_q] <= 1'b0;
        dirty_q[vic_q] <= 1'b0;
      end
      if (wr_hit) dirty_q[hw] <= 1'b1;
      if (install) begin
        tag_q[vic_q] <= vtag_q;
        valid_q[vic_q] <= 1'b1;
        dirty_q[vic_q] <= 1'b0;
      end
    end
  always_ff @(posedge clk) begin
    if (wr_hit)
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (byte_en[b]) data_q[hw][lookup_offset][8*b +: 8] <= write_data[8*b +: 8];
    if (fill_beat) data_q[vic_q][cnt_q] <= fill_data;
  end
endmodule
